spi_master_out: RTL and testbench
=================================

Name: spi_master_out

Overview:
- Output-only SPI master. Serialises a BITS-wide word onto MOSI for write-only peripherals such as DACs and digital pots.
- Transmit-side counterpart of the team's input-only SPI master, using the same bus conventions: CS active-low, SCK idles high, peripheral samples MOSI on SCK rising edge.
- Sits between the controller output register and the off-chip pins; one transaction per start request.

Parameters:
BITS, 4, word length in bits shifted per transaction (>=2)
HALF, 3, clk cycles per SCK half-period (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request transaction; sampled only when idle
data_in  input  BITS  word to send; latched on accepted start
mosi  output  1  serial data out, MSB first
sck  output  1  SPI clock, idle high
cs  output  1  chip select, active low
busy  output  1  high while a transaction is in progress
done  output  1  one-cycle pulse when cs deasserts

Behaviour:
- Clocking: one clock (clk); reset is asynchronous, active-high. While reset is high, all state takes reset values immediately, regardless of clk.
- Reset values: sck=1, cs=1, mosi=0, busy=0, done=0, shift register=0, bit counter=0, divider=0, state=IDLE.
- Divider: counts 0..HALF-1 in every non-IDLE state and wraps. A state advances on the cycle the divider equals HALF-1. Divider clears on entry to LEAD.
- States: IDLE, LEAD, SCK_LO, SCK_HI, TRAIL.
- IDLE:
  - cs=1, sck=1, busy=0.
  - On start=1 at a clk edge (call it edge 0): latch data_in, cs<=0, busy<=1, mosi<=data_in[BITS-1], go to LEAD.
- LEAD (HALF cycles): sck stays 1. At end: sck<=0, go to SCK_LO.
- SCK_LO (HALF cycles): at end, sck<=1, bit counter +1, go to SCK_HI.
- SCK_HI (HALF cycles): at end:
  - If bit counter==BITS, go to TRAIL with sck held 1.
  - Otherwise sck<=0, shift register left by one, mosi<=next bit, go to SCK_LO.
- TRAIL (HALF cycles): at end, cs<=1, busy<=0, done<=1 for that one cycle, mosi<=0, bit counter<=0, go to IDLE.
- Timing, edges counted from edge 0:
  - sck falls at edge H, (2k+1)H.
  - sck rises at edge 2kH for k=1..BITS.
  - mosi changes only coincident with sck falling edges, so it is stable for HALF cycles before each rising edge.
  - cs rises at edge (2*BITS+2)*H.
  - BITS=4, HALF=3: falls 3, 9, 15, 21; rises 6, 12, 18, 24; cs high at 30.
- Bit counter width: $clog2(BITS+1). No wrap in normal operation; compared against BITS, not zero.
- start while busy=1: ignored, no queuing. data_in changes while busy: no effect.
- start sampled high in the same cycle done=1 is accepted. Minimum cs-high gap between back-to-back transactions is 1 cycle.
- start held continuously high: transactions repeat with a 1-cycle cs-high gap, each using data_in as sampled at its own accept.
- Reset mid-transaction: cs goes high and sck goes high asynchronously. No done pulse is generated and the partial word is discarded.
- done never asserts outside the TRAIL-to-IDLE transition. busy equals !cs at all times.

Optional Feature:
- Macro SPI_OUT_INVERT_EN.
- Defined: mosi drives the inverted data bit, matching the inverting line driver that the input master compensates for. The idle/reset mosi level becomes 1.
- Undefined: mosi drives true data; idle/reset level is 0.
- Timing is identical in both builds.

Test Plan:
1. Assert reset for 2 cycles at an arbitrary phase -> sck=1, cs=1, mosi=0, busy=0, done=0 immediately, before the next clk edge.
2. BITS=4, HALF=3, data_in=4'b1011, pulse start -> mosi sampled at sck rises (edges 6, 12, 18, 24) = 1,0,1,1; cs low for exactly 30 cycles; exactly one done pulse, at edge 30.
3. During transaction 2, pulse start at edge 10 with data_in=4'b0000 -> ignored; bits unchanged; no second transaction.
4. start held high with data_in=4'b1100 then 4'b0011 -> two transactions with cs high exactly 1 cycle between them; first sends 1100, second sends 0011.
5. data_in=4'b1111, assert reset at edge 10 -> cs=1 and sck=1 asynchronously; no done; subsequent start sends a full correct word.
6. With SPI_OUT_INVERT_EN defined, data_in=4'b1011 -> mosi at rises = 0,1,0,0; idle mosi=1; edge timing identical to scenario 2.

Source files
------------

// File: rtl/spi_master_out.sv
// spi_master_out: output-only SPI master, MSB first, CS active-low, SCK idles high.
// Define SPI_OUT_INVERT_EN to drive inverted MOSI data (idle/reset level becomes 1).
module spi_master_out #(
   parameter int BITS = 4,
   parameter int HALF = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [BITS-1:0] data_in,
   output logic            mosi,
   output logic            sck,
   output logic            cs,
   output logic            busy,
   output logic            done
);
   localparam int CW = $clog2(BITS + 1);
   localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(BITS);
   localparam logic [DW-1:0] DMAX = DW'(HALF - 1);
`ifdef SPI_OUT_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, LEAD, SCK_LO, SCK_HI, TRAIL} state_t;
   state_t          state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BITS-1:0] sh_q, sh_d;
   logic            sck_q, sck_d, cs_q, cs_d, mosi_q, mosi_d, done_q, done_d;
   logic            tick;
   assign tick = (div_q == DMAX);
   always_comb begin
      state_d = state_q;
      div_d   = (state_q == IDLE || tick) ? '0 : div_q + DW'(1);
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      sck_d   = sck_q;
      cs_d    = cs_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = LEAD;
            sh_d    = data_in;
            cs_d    = 1'b0;
            mosi_d  = data_in[BITS-1] ^ INV;
         end
         LEAD: if (tick) begin
            sck_d   = 1'b0;
            state_d = SCK_LO;
         end
         SCK_LO: if (tick) begin
            sck_d   = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            state_d = SCK_HI;
         end
         SCK_HI: if (tick) begin
            if (cnt_q == LAST) state_d = TRAIL;
            else begin
               // next bit goes out with the falling edge so it is stable a full half-period
               sck_d   = 1'b0;
               sh_d    = sh_q << 1;
               mosi_d  = sh_q[BITS-2] ^ INV;
               state_d = SCK_LO;
            end
         end
         TRAIL: if (tick) begin
            cs_d    = 1'b1;
            done_d  = 1'b1;
            mosi_d  = INV;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         sck_q   <= 1'b1;
         cs_q    <= 1'b1;
         mosi_q  <= INV;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
      end
   end
   assign mosi = mosi_q;
   assign sck  = sck_q;
   assign cs   = cs_q;
   assign busy = ~cs_q;
   assign done = done_q;
endmodule

// File: tb/tb_spi_master_out.sv
// tb_spi_master_out: table vectors, corner sequences and random traffic checked against a word-level model.
module tb_spi_master_out;
   localparam int BITS = 4;
   localparam int HALF = 3;
   localparam int TOT  = (2 * BITS + 2) * HALF;
`ifdef SPI_OUT_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [BITS-1:0] data_in = '0;
   logic mosi, sck, cs, busy, done;
   int checks = 0, errors = 0, cyc = 0;

   spi_master_out #(.BITS(BITS), .HALF(HALF)) dut (
      .clk(clk), .reset(reset), .start(start), .data_in(data_in),
      .mosi(mosi), .sck(sck), .cs(cs), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Model: a transaction occupies TOT edges after its accept; the edge after that may accept again.
   logic [BITS-1:0] exp_q[$];
   int m_left = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
         m_left = 0;
         exp_q.delete();
      end else if (m_left > 0) m_left--;
      else if (start) begin
         exp_q.push_back(data_in);
         m_left = TOT;
      end
   end

   // Monitor: reconstructs words from MOSI sampled at SCK rises and checks edge timing.
   logic pcs = 1'b1, psck = 1'b1, pmosi = 1'b0;
   logic [BITS-1:0] w = '0, last_word = '0;
   int t0 = 0, nr = 0, last_len = 0, ntx = 0, dones = 0;
   initial forever begin
      @(negedge clk);
      chk("busy_eq_not_cs", int'(busy), int'(!cs));
      if (!reset) begin
         chk("done_only_at_cs_rise", int'(done), int'(cs && !pcs));
         if (done) dones++;
         chk("mosi_change_on_sck_fall", int'((mosi != pmosi) && !(psck && !sck) && (cs == pcs)), 0);
         if (!cs && pcs) begin
            t0 = cyc;
            nr = 0;
            w  = '0;
         end
         if (!cs && sck && !psck) begin
            nr++;
            chk("rise_time", cyc - t0, 2 * nr * HALF);
            w = {w[BITS-2:0], mosi ^ INV};
         end
         if (cs) chk("idle_mosi", int'(mosi), int'(INV));
         if (cs && !pcs) begin
            last_len  = cyc - t0;
            last_word = w;
            ntx++;
            chk("cs_low_len", last_len, TOT);
            chk("rise_count", nr, BITS);
            if (exp_q.size() == 0) chk("unexpected_tx", 1, 0);
            else chk("word", int'(w), int'(exp_q.pop_front()));
         end
      end
      pcs = cs;
      psck = sck;
      pmosi = mosi;
   end

   task automatic wait_done();
      for (int i = 0; i < 4 * TOT; i++) begin
         @(negedge clk);
         if (done) return;
      end
      chk("done_timeout", 0, 1);
   endtask

   task automatic pulse(input logic [BITS-1:0] d);
      @(negedge clk);
      data_in = d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      data_in = BITS'($urandom);
   endtask

   typedef struct {
      logic [BITS-1:0] d;
      logic [BITS-1:0] exp_w;
      int              exp_len;
   } vec_t;
   vec_t vecs[6];

   initial begin
      int n0, d0;
      vecs[0] = '{4'b1011, 4'b1011, 30};
      vecs[1] = '{4'b0000, 4'b0000, 30};
      vecs[2] = '{4'b1111, 4'b1111, 30};
      vecs[3] = '{4'b0110, 4'b0110, 30};
      vecs[4] = '{4'b1001, 4'b1001, 30};
      vecs[5] = '{4'b0001, 4'b0001, 30};
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_sck", int'(sck), 1);
      chk("rst_cs", int'(cs), 1);
      chk("rst_mosi", int'(mosi), int'(INV));
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         pulse(vecs[i].d);
         wait_done();
         chk("vec_word", int'(last_word), int'(vecs[i].exp_w));
         chk("vec_len", last_len, vecs[i].exp_len);
         repeat (2) @(negedge clk);
      end
      // start during a transaction is ignored
      n0 = ntx;
      pulse(4'b1011);
      repeat (8) @(negedge clk);
      pulse(4'b0000);
      wait_done();
      chk("ignored_word", int'(last_word), 11);
      repeat (3 * TOT) @(negedge clk);
      chk("ignored_ntx", ntx, n0 + 1);
      chk("ignored_busy", int'(busy), 0);
      // start held high: back-to-back with one idle cycle
      @(negedge clk);
      data_in = 4'b1100;
      start = 1'b1;
      repeat (5) @(negedge clk);
      data_in = 4'b0011;
      wait_done();
      chk("b2b_first", int'(last_word), 12);
      @(negedge clk);
      chk("b2b_gap_cs", int'(cs), 0);
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_done();
      chk("b2b_second", int'(last_word), 3);
      repeat (5) @(negedge clk);
      // asynchronous reset mid-transaction
      n0 = ntx;
      d0 = dones;
      pulse(4'b1111);
      repeat (8) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_cs", int'(cs), 1);
      chk("async_sck", int'(sck), 1);
      chk("async_busy", int'(busy), 0);
      chk("async_mosi", int'(mosi), int'(INV));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2 * TOT) @(negedge clk);
      chk("async_no_done", dones, d0);
      chk("async_no_tx", ntx, n0);
      pulse(4'b1010);
      wait_done();
      chk("after_reset_word", int'(last_word), 10);
      // random traffic against the model
      n0 = ntx;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 7) == 0);
         data_in = BITS'($urandom);
      end
      start = 1'b0;
      repeat (2 * TOT) @(negedge clk);
      chk("rand_queue_empty", exp_q.size(), 0);
      chk("rand_progress", int'(ntx > n0 + 20), 1);
      chk("rand_idle_cs", int'(cs), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
